// File: rtl/tape_pkg.sv
// Shared tape timing defaults, FSM state codes and pulse-count classification
// used by the save decoder and the RAM-injecting loader.
package tape_pkg;

    localparam int unsigned TICK_W        = 18;
    localparam int unsigned DEF_MIN_HI    = 260;
    localparam int unsigned DEF_GAP_TICKS = 3900;
    localparam int unsigned DEF_END_TICKS = 130000;
    localparam int unsigned DEF_ADDR_W    = 14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [3:0] ZERO_MIN = 4'd3;
    localparam logic [3:0] ZERO_MAX = 4'd5;
    localparam logic [3:0] ONE_MIN  = 4'd7;
    localparam logic [3:0] ONE_MAX  = 4'd11;

    // Returns {bad_count, bit}; an unrecognised burst length decodes as 0.
    function automatic logic [1:0] classify_pulses(input logic [3:0] cnt);
        logic [1:0] res;
        res = 2'b10;
        if (cnt >= ZERO_MIN && cnt <= ZERO_MAX) begin
            res = 2'b00;
        end else if (cnt >= ONE_MIN && cnt <= ONE_MAX) begin
            res = 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/tape_pulse_timer.sv
// MIC front end: 2-flop synchroniser, ce-rate edge detect, glitch split of
// falling edges against MIN_HI, and an 18-bit saturating tick counter.
module tape_pulse_timer
    import tape_pkg::*;
#(
    parameter int unsigned MIN_HI = DEF_MIN_HI
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              i_mic,
    input  logic              i_clr,
    output logic              o_rise_c,
    output logic              o_fall_long_c,
    output logic              o_fall_short_c,
    output logic [TICK_W-1:0] o_ticks
);

    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    logic [1:0]        r_sync;
    logic              r_lvl;
    logic [TICK_W-1:0] r_ticks;
    logic              w_mic;
    logic              w_fall;

    assign w_mic = r_sync[1];

    // Level is sampled at ce rate so an edge persists until the next tick sees it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_lvl   <= 1'b0;
            r_ticks <= '0;
        end else begin
            r_sync <= {r_sync[0], i_mic};
            if (ce) begin
                r_lvl <= w_mic;
                if (i_clr) begin
                    r_ticks <= '0;
                end else if (r_ticks != TICK_MAX) begin
                    r_ticks <= r_ticks + TICK_W'(1);
                end
            end
        end
    end

    assign w_fall         = ce & ~w_mic & r_lvl;
    assign o_rise_c       = ce & w_mic & ~r_lvl;
    assign o_fall_long_c  = w_fall & (r_ticks >= TICK_W'(MIN_HI));
    assign o_fall_short_c = w_fall & (r_ticks <  TICK_W'(MIN_HI));
    assign o_ticks        = r_ticks;

endmodule

// File: rtl/tape_save_decoder.sv
// Decodes ZX80/ZX81 SAVE pulse bursts into bytes written to the save buffer.
// Build option TAPE_SAVE_PFILE_EN skips the ZX81 program name before storing.
module tape_save_decoder
    import tape_pkg::*;
#(
    parameter int unsigned MIN_HI    = DEF_MIN_HI,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned END_TICKS = DEF_END_TICKS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              arm,
    input  logic              mic,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   length,
    output logic              active,
    output logic              done,
    output logic              err,
    output logic              overflow
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    logic [1:0]        r_state, r_ctx;
    logic [3:0]        r_pcnt;
    logic [7:0]        r_shift;
    logic [2:0]        r_bcnt;
    logic              r_arm, r_name;
    logic              r_wr, r_active, r_done, r_err, r_ovf;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [LEN_W-1:0]  r_length;

    logic [1:0]        w_state_nx, w_ctx_nx;
    logic [3:0]        w_pcnt_nx;
    logic [7:0]        w_shift_nx, w_data_nx, w_byte;
    logic [2:0]        w_bcnt_nx;
    logic              w_arm_nx, w_name_nx;
    logic              w_wr_nx, w_active_nx, w_done_nx, w_err_nx, w_ovf_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [LEN_W-1:0]  w_length_nx;
    logic [1:0]        w_cls;
    logic              w_tick_clr;
    logic              w_rise, w_fall_long, w_fall_short;
    logic [TICK_W-1:0] w_ticks;

    tape_pulse_timer #(
        .MIN_HI (MIN_HI)
    ) u_timer (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce             (ce),
        .i_mic          (mic),
        .i_clr          (w_tick_clr),
        .o_rise_c       (w_rise),
        .o_fall_long_c  (w_fall_long),
        .o_fall_short_c (w_fall_short),
        .o_ticks        (w_ticks)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ctx    <= ST_IDLE;
            r_pcnt   <= '0;
            r_shift  <= '0;
            r_bcnt   <= '0;
            r_arm    <= 1'b0;
            r_name   <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_length <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ctx    <= w_ctx_nx;
            r_pcnt   <= w_pcnt_nx;
            r_shift  <= w_shift_nx;
            r_bcnt   <= w_bcnt_nx;
            r_arm    <= w_arm_nx;
            r_name   <= w_name_nx;
            r_wr     <= w_wr_nx;
            r_addr   <= w_addr_nx;
            r_data   <= w_data_nx;
            r_length <= w_length_nx;
            r_active <= w_active_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_ovf    <= w_ovf_nx;
        end
    end

    // Next state; wr/done default low so they drop on the following clk_sys cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_ctx_nx    = r_ctx;
        w_pcnt_nx   = r_pcnt;
        w_shift_nx  = r_shift;
        w_bcnt_nx   = r_bcnt;
        w_arm_nx    = r_arm;
        w_name_nx   = r_name;
        w_wr_nx     = 1'b0;
        w_addr_nx   = r_addr;
        w_data_nx   = r_data;
        w_length_nx = r_length;
        w_active_nx = r_active;
        w_done_nx   = 1'b0;
        w_err_nx    = r_err;
        w_ovf_nx    = r_ovf;
        w_cls       = 2'b00;
        w_byte      = 8'h00;
        w_tick_clr  = 1'b0;

        if (ce) begin
            w_arm_nx = arm;
            if (arm && !r_arm) begin
                w_err_nx = 1'b0;
                w_ovf_nx = 1'b0;
            end
            if (!arm) begin
                if (r_state != ST_IDLE) begin
                    w_tick_clr = 1'b1;
                end
                w_state_nx  = ST_IDLE;
                w_active_nx = 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_state_nx  = ST_HIGH;
                            w_ctx_nx    = ST_GAP;
                            w_active_nx = 1'b1;
                            w_pcnt_nx   = '0;
                            w_shift_nx  = '0;
                            w_bcnt_nx   = '0;
                            w_length_nx = '0;
                            w_tick_clr  = 1'b1;
`ifdef TAPE_SAVE_PFILE_EN
                            w_name_nx   = 1'b1;
`else
                            w_name_nx   = 1'b0;
`endif
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall_long) begin
                            w_pcnt_nx  = (r_pcnt == 4'hF) ? r_pcnt : r_pcnt + 4'd1;
                            w_state_nx = ST_LOW;
                            w_tick_clr = 1'b1;
                        end else if (w_fall_short) begin
                            // Glitch: resume the previous low context with timing untouched.
                            w_state_nx = r_ctx;
                        end
                    end
                    ST_LOW: begin
                        if (w_ticks == TICK_W'(GAP_TICKS)) begin
                            w_cls      = classify_pulses(r_pcnt);
                            w_byte     = {r_shift[6:0], w_cls[0]};
                            w_shift_nx = w_byte;
                            w_bcnt_nx  = r_bcnt + 3'd1;
                            w_pcnt_nx  = '0;
                            w_tick_clr = 1'b1;
                            if (w_cls[1]) begin
                                w_err_nx = 1'b1;
                            end
                            if (r_bcnt == 3'd7) begin
                                if (r_name) begin
                                    if (w_byte[7]) begin
                                        w_name_nx = 1'b0;
                                    end
                                end else if (r_length[ADDR_W]) begin
                                    w_ovf_nx = 1'b1;
                                end else begin
                                    w_wr_nx     = 1'b1;
                                    w_addr_nx   = r_length[ADDR_W-1:0];
                                    w_data_nx   = w_byte;
                                    w_length_nx = r_length + LEN_W'(1);
                                end
                            end
                            // A rise coinciding with expiry starts the next bit directly.
                            if (w_rise) begin
                                w_state_nx = ST_HIGH;
                                w_ctx_nx   = ST_GAP;
                            end else begin
                                w_state_nx = ST_GAP;
                            end
                        end else if (w_rise) begin
                            w_state_nx = ST_HIGH;
                            w_ctx_nx   = ST_LOW;
                            w_tick_clr = 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (w_rise) begin
                            w_state_nx = ST_HIGH;
                            w_ctx_nx   = ST_GAP;
                            w_pcnt_nx  = '0;
                            w_tick_clr = 1'b1;
                        end else if (w_ticks == TICK_W'(END_TICKS)) begin
                            w_state_nx  = ST_IDLE;
                            w_done_nx   = 1'b1;
                            w_active_nx = 1'b0;
                            w_tick_clr  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nx = ST_IDLE;
                        w_tick_clr = 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr       = r_wr;
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign length   = r_length;
    assign active   = r_active;
    assign done     = r_done;
    assign err      = r_err;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_tape_save_decoder.sv
// Self-checking bench for tape_save_decoder with shortened tick timing and an
// 8-byte buffer; expected buffer writes go through a scoreboard queue.
module tb_tape_save_decoder;

    localparam int unsigned MIN_HI    = 3;
    localparam int unsigned GAP_TICKS = 20;
    localparam int unsigned END_TICKS = 80;
    localparam int unsigned ADDR_W    = 3;

    localparam int T_HI   = 6;
    localparam int T_LO   = 6;
    localparam int T_GAPX = 24;
    localparam int T_END  = 150;
    localparam int NVEC   = 9;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        logic [7:0] din;
        int         bad_idx;
        int         bad_n;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    logic              clk_sys = 1'b0;
    logic              reset, ce, arm, mic;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   length;
    logic              active, done, err, overflow;

    wr_t               exp_q[$];
    wr_t               mon_e;
    int                checks = 0;
    int                failures = 0;
    int                done_cnt = 0;
    int                wr_cnt = 0;
    int                m_len = 0;
    int                last_addr = -1;

    tape_save_decoder #(
        .MIN_HI    (MIN_HI),
        .GAP_TICKS (GAP_TICKS),
        .END_TICKS (END_TICKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .arm      (arm),
        .mic      (mic),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .length   (length),
        .active   (active),
        .done     (done),
        .err      (err),
        .overflow (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (2 * n) @(negedge clk_sys);
    endtask

    task automatic send_pulses(input int n);
        for (int p = 0; p < n; p++) begin
            mic = 1'b1;
            ticks(T_HI);
            mic = 1'b0;
            ticks(T_LO);
        end
    endtask

    task automatic send_bit(input int n);
        send_pulses(n);
        ticks(T_GAPX);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bad_idx, input int bad_n);
        for (int i = 0; i < 8; i++) begin
            if (i == bad_idx) send_bit(bad_n);
            else send_bit(b[7 - i] ? 9 : 4);
        end
    endtask

    // Reference model of the buffer: store while there is room, else drop.
    task automatic expect_byte(input logic [7:0] d);
        wr_t e;
        if (m_len < (1 << ADDR_W)) begin
            e.addr = ADDR_W'(m_len);
            e.data = d;
            exp_q.push_back(e);
            m_len++;
        end
    endtask

    task automatic start_block();
        arm = 1'b0;
        ticks(3);
        arm = 1'b1;
        ticks(3);
        m_len = 0;
    endtask

    initial begin
        vec_t vecs [NVEC];
        int   d0;
        int   w0;

        vecs[0] = '{8'hA5, -1,  0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, -1,  0, 8'h3C, 1'b0};
        vecs[2] = '{8'hFF,  3,  6, 8'hEF, 1'b1};
        vecs[3] = '{8'h81,  7,  2, 8'h80, 1'b1};
        vecs[4] = '{8'h00,  0, 12, 8'h00, 1'b1};
        vecs[5] = '{8'h00,  2,  7, 8'h20, 1'b0};
        vecs[6] = '{8'h00,  5, 11, 8'h04, 1'b0};
        vecs[7] = '{8'hFF,  0,  3, 8'h7F, 1'b0};
        vecs[8] = '{8'hFF,  7,  5, 8'hFE, 1'b0};

        reset = 1'b1;
        ce    = 1'b0;
        arm   = 1'b0;
        mic   = 1'b0;

        fork
            forever begin
                @(negedge clk_sys);
                ce = ~ce;
            end
            forever begin
                @(negedge clk_sys);
                if (done) done_cnt++;
                if (wr) begin
                    wr_cnt++;
                    last_addr = int'(wr_addr);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_wr: addr %0d data 0x%02h, no write expected",
                                 wr_addr, wr_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_addr", int'(wr_addr), int'(mon_e.addr));
                        chk("wr_data", int'(wr_data), int'(mon_e.data));
                    end
                end
            end
        join_none

        repeat (6) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_wr",       int'(wr),       0);
        chk("rst_wr_addr",  int'(wr_addr),  0);
        chk("rst_wr_data",  int'(wr_data),  0);
        chk("rst_length",   int'(length),   0);
        chk("rst_active",   int'(active),   0);
        chk("rst_done",     int'(done),     0);
        chk("rst_err",      int'(err),      0);
        chk("rst_overflow", int'(overflow), 0);

`ifdef TAPE_SAVE_PFILE_EN
        start_block();
        d0 = done_cnt;
        expect_byte(8'h00);
        expect_byte(8'h7F);
        send_byte(8'h26, -1, 0);
        send_byte(8'hB7, -1, 0);
        send_byte(8'h00, -1, 0);
        send_byte(8'h7F, -1, 0);
        ticks(T_END);
        chk("pf_length",  int'(length), 2);
        chk("pf_done",    done_cnt - d0, 1);
        chk("pf_pending", exp_q.size(), 0);

        start_block();
        d0 = done_cnt;
        send_byte(8'h26, -1, 0);
        ticks(T_END);
        chk("pf_name_only_length", int'(length), 0);
        chk("pf_name_only_done",   done_cnt - d0, 1);
`else
        // Single-byte blocks: plain bytes, bad burst lengths and class boundaries.
        for (int v = 0; v < NVEC; v++) begin
            start_block();
            d0 = done_cnt;
            expect_byte(vecs[v].exp_data);
            send_byte(vecs[v].din, vecs[v].bad_idx, vecs[v].bad_n);
            ticks(T_END);
            chk($sformatf("v%0d_done", v),    done_cnt - d0, 1);
            chk($sformatf("v%0d_length", v),  int'(length), 1);
            chk($sformatf("v%0d_err", v),     int'(err), int'(vecs[v].exp_err));
            chk($sformatf("v%0d_active", v),  int'(active), 0);
            chk($sformatf("v%0d_pending", v), exp_q.size(), 0);
        end

        // Short spike in the gap after bit 3 must not disturb the byte.
        start_block();
        d0 = done_cnt;
        expect_byte(8'h5A);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                send_pulses(9);
                ticks(18);
                mic = 1'b1;
                ticks(1);
                mic = 1'b0;
                ticks(10);
            end else begin
                send_bit((8'h5A >> (7 - i)) & 1 ? 9 : 4);
            end
        end
        ticks(T_END);
        chk("spike_done",    done_cnt - d0, 1);
        chk("spike_length",  int'(length), 1);
        chk("spike_err",     int'(err), 0);
        chk("spike_pending", exp_q.size(), 0);

        // Arm dropped after three bits, then a fresh block.
        start_block();
        d0 = done_cnt;
        w0 = wr_cnt;
        send_bit(9);
        send_bit(4);
        send_bit(9);
        chk("armdrop_active_mid", int'(active), 1);
        arm = 1'b0;
        ticks(2);
        chk("armdrop_active", int'(active), 0);
        ticks(T_END);
        chk("armdrop_no_done", done_cnt - d0, 0);
        chk("armdrop_no_wr",   wr_cnt - w0, 0);
        arm = 1'b1;
        ticks(2);
        m_len = 0;
        expect_byte(8'h3C);
        send_byte(8'h3C, -1, 0);
        ticks(T_END);
        chk("rearm_done",    done_cnt - d0, 1);
        chk("rearm_length",  int'(length), 1);
        chk("rearm_pending", exp_q.size(), 0);

        // Reset during the eighth bit of the second byte.
        start_block();
        expect_byte(8'h96);
        send_byte(8'h96, -1, 0);
        for (int i = 0; i < 7; i++) send_bit(9);
        send_pulses(9);
        ticks(5);
        d0 = done_cnt;
        w0 = wr_cnt;
        reset = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("midrst_active", int'(active), 0);
        chk("midrst_length", int'(length), 0);
        ticks(T_END);
        chk("midrst_no_wr",   wr_cnt - w0, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_pending", exp_q.size(), 0);

        // One byte more than the buffer holds.
        start_block();
        d0 = done_cnt;
        w0 = wr_cnt;
        for (int i = 0; i < (1 << ADDR_W) + 1; i++) begin
            expect_byte(8'(8'h10 + i));
            send_byte(8'(8'h10 + i), -1, 0);
        end
        ticks(T_END);
        chk("ovf_flag",      int'(overflow), 1);
        chk("ovf_length",    int'(length), 1 << ADDR_W);
        chk("ovf_last_addr", last_addr, (1 << ADDR_W) - 1);
        chk("ovf_writes",    wr_cnt - w0, 1 << ADDR_W);
        chk("ovf_done",      done_cnt - d0, 1);
        chk("ovf_pending",   exp_q.size(), 0);
        arm = 1'b0;
        ticks(2);
        chk("ovf_held_disarmed", int'(overflow), 1);
        arm = 1'b1;
        ticks(2);
        chk("ovf_cleared", int'(overflow), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
